// File: rtl/serv_csr_mi_pkg.sv
// Shared constants and lane helpers for the machine-mode CSR datapath.
// Source selects, trap cause codes and CSR field bit positions.
package serv_csr_mi_pkg;

  localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
  localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;
  localparam logic [1:0] CSR_SOURCE_SET = 2'b10;
  localparam logic [1:0] CSR_SOURCE_CLR = 2'b11;

  localparam logic [3:0] MCAUSE_MSI    = 4'd3;
  localparam logic [3:0] MCAUSE_MTI    = 4'd7;
  localparam logic [3:0] MCAUSE_MEI    = 4'd11;
  localparam logic [3:0] MCAUSE_EBREAK = 4'd3;
  localparam logic [3:0] MCAUSE_ECALL  = 4'd11;
  localparam logic [3:0] MCAUSE_LMIS   = 4'd4;
  localparam logic [3:0] MCAUSE_SMIS   = 4'd6;
  localparam logic [3:0] MCAUSE_JMIS   = 4'd0;

  localparam logic [4:0] MSTATUS_MIE  = 5'd3;
  localparam logic [4:0] MSTATUS_MPIE = 5'd7;
  localparam logic [4:0] MIE_MSI      = 5'd3;
  localparam logic [4:0] MIE_MTI      = 5'd7;
  localparam logic [4:0] MIE_MEI      = 5'd11;
  localparam logic [4:0] MCAUSE_INT   = 5'd31;

  // Field bit k sits in the chunk when (k - pos) mod 32 < w.
  function automatic logic lane_hit(
    input logic [4:0] k,
    input logic [4:0] pos,
    input int         w
  );
    logic [4:0] off;
    off = k - pos;
    return int'(off) < w;
  endfunction

  function automatic logic lane_bit(
    input logic [31:0] v,
    input logic [4:0]  k,
    input logic [4:0]  pos
  );
    return v[5'(k - pos)];
  endfunction

endpackage

// File: rtl/serv_csr_irq.sv
// Interrupt pending, fixed-priority encode and registered irq request.
// Level sensitive: sampled at every non-init instruction end.
module serv_csr_irq
  import serv_csr_mi_pkg::*;
#(
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init,
  input  logic       i_cnt_done,
  input  logic       i_trap,
  input  logic       i_mstatus_mie,
  input  logic       i_mie_msie,
  input  logic       i_mie_mtie,
  input  logic       i_mie_meie,
  input  logic       i_msip,
  input  logic       i_mtip,
  input  logic       i_meip,
  output logic       o_new_irq,
  output logic [3:0] o_irq_code
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic [2:0] pend;
  logic [3:0] code;

  assign pend = {i_meip & i_mie_meie,
                 i_msip & i_mie_msie,
                 i_mtip & i_mie_mtie};

  always_comb begin
    code = MCAUSE_MTI;
    if (pend[2])      code = MCAUSE_MEI;
    else if (pend[1]) code = MCAUSE_MSI;
  end

  // Trap completion wins over a fresh request in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if (RST_EN) o_new_irq <= 1'b0;
    end else if (i_trap & i_cnt_done) begin
      o_new_irq <= 1'b0;
    end else if (!i_init & i_cnt_done) begin
      o_new_irq <= i_mstatus_mie & (|pend);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_init & i_cnt_done) o_irq_code <= code;
  end

endmodule

// File: rtl/serv_csr_mi.sv
// Chunked machine-mode CSR datapath: mstatus, mie, mip, mcause.
// Builds CSR read/write data per chunk; RF-held CSRs pass through.
module serv_csr_mi
  import serv_csr_mi_pkg::*;
#(
  parameter int    W              = 1,
  parameter int    B              = W - 1,
  parameter string RESET_STRATEGY = "MINI",
  parameter bit    WITH_MSIP_MEIP = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic         i_en,
  input  logic [4:0]   i_bitpos,
  input  logic         i_cnt_done,
  input  logic         i_mem_op,
  input  logic         i_mem_cmd,
  input  logic         i_e_op,
  input  logic         i_ebreak,
  input  logic         i_trap,
  input  logic         i_mret,
  input  logic         i_mstatus_en,
  input  logic         i_mie_en,
  input  logic         i_mip_en,
  input  logic         i_mcause_en,
  input  logic [1:0]   i_csr_source,
  input  logic         i_csr_d_sel,
  input  logic [B:0]   i_csr_imm,
  input  logic [B:0]   i_rs1,
  input  logic [B:0]   i_rf_csr_out,
  input  logic         i_mtip,
  input  logic         i_msip,
  input  logic         i_meip,
  output logic         o_new_irq,
  output logic [B:0]   o_csr_in,
  output logic [B:0]   o_q
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_msie;
  logic        mie_mtie;
  logic        mie_meie;
  logic        mcause_int;
  logic [3:0]  mcause_code;
  logic [3:0]  irq_code;
  logic [3:0]  exc_code;
  logic        msip_l;
  logic        meip_l;
  logic        trap_done;
  logic [B:0]  d;
  logic [B:0]  csr_out;
  logic [31:0] word;
  logic [31:0] wd32;

  assign msip_l    = WITH_MSIP_MEIP & i_msip;
  assign meip_l    = WITH_MSIP_MEIP & i_meip;
  assign trap_done = i_trap & i_cnt_done;
  assign d         = i_csr_d_sel ? i_csr_imm : i_rs1;

  always_comb begin
    word = '0;
    if (i_mstatus_en) begin
      word[MSTATUS_MIE]  = mstatus_mie;
      word[MSTATUS_MPIE] = mstatus_mpie;
      word[12:11]        = 2'b11;
    end
    if (i_mie_en) begin
      word[MIE_MSI] = mie_msie;
      word[MIE_MTI] = mie_mtie;
      word[MIE_MEI] = mie_meie;
    end
    if (i_mip_en) begin
      word[MIE_MSI] = msip_l;
      word[MIE_MTI] = i_mtip;
      word[MIE_MEI] = meip_l;
    end
    if (i_mcause_en) begin
      word[MCAUSE_INT] = mcause_int;
      word[3:0]        = mcause_code;
    end
  end

  always_comb begin
    csr_out = '0;
    for (int l = 0; l < W; l++)
      csr_out[l] = word[5'(i_bitpos + 5'(l))];
  end

  assign o_q = i_en ? (i_rf_csr_out | csr_out) : '0;

  always_comb begin
    unique case (i_csr_source)
      CSR_SOURCE_EXT: o_csr_in = d;
      CSR_SOURCE_SET: o_csr_in = o_q | d;
      CSR_SOURCE_CLR: o_csr_in = o_q & ~d;
      default:        o_csr_in = o_q;
    endcase
  end

  always_comb begin
    wd32      = '0;
    wd32[B:0] = o_csr_in;
  end

  always_comb begin
    unique case (1'b1)
      i_e_op & i_ebreak:              exc_code = MCAUSE_EBREAK;
      i_e_op & ~i_ebreak:             exc_code = MCAUSE_ECALL;
      ~i_e_op & i_mem_op & i_mem_cmd:  exc_code = MCAUSE_SMIS;
      ~i_e_op & i_mem_op & ~i_mem_cmd: exc_code = MCAUSE_LMIS;
      default:                        exc_code = MCAUSE_JMIS;
    endcase
  end

  // Trap beats mret beats an explicit mstatus write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if (RST_EN) begin
        mstatus_mie  <= 1'b0;
        mstatus_mpie <= 1'b0;
        mie_msie     <= 1'b0;
        mie_mtie     <= 1'b0;
        mie_meie     <= 1'b0;
      end
    end else begin
      if (trap_done) begin
        mstatus_mie  <= 1'b0;
        mstatus_mpie <= mstatus_mie;
      end else if (i_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (i_en & i_mstatus_en) begin
        if (lane_hit(MSTATUS_MIE, i_bitpos, W))
          mstatus_mie <= lane_bit(wd32, MSTATUS_MIE, i_bitpos);
        if (lane_hit(MSTATUS_MPIE, i_bitpos, W))
          mstatus_mpie <= lane_bit(wd32, MSTATUS_MPIE, i_bitpos);
      end
      if (i_en & i_mie_en) begin
        if (WITH_MSIP_MEIP && lane_hit(MIE_MSI, i_bitpos, W))
          mie_msie <= lane_bit(wd32, MIE_MSI, i_bitpos);
        if (lane_hit(MIE_MTI, i_bitpos, W))
          mie_mtie <= lane_bit(wd32, MIE_MTI, i_bitpos);
        if (WITH_MSIP_MEIP && lane_hit(MIE_MEI, i_bitpos, W))
          mie_meie <= lane_bit(wd32, MIE_MEI, i_bitpos);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (trap_done) begin
      mcause_int  <= o_new_irq;
      mcause_code <= o_new_irq ? irq_code : exc_code;
    end else if (i_en & i_mcause_en) begin
      if (lane_hit(MCAUSE_INT, i_bitpos, W))
        mcause_int <= lane_bit(wd32, MCAUSE_INT, i_bitpos);
      for (int k = 0; k < 4; k++)
        if (lane_hit(5'(k), i_bitpos, W))
          mcause_code[k] <= lane_bit(wd32, 5'(k), i_bitpos);
    end
  end

  serv_csr_irq #(
    .RESET_STRATEGY (RESET_STRATEGY)
  ) u_irq (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_init         (i_init),
    .i_cnt_done     (i_cnt_done),
    .i_trap         (i_trap),
    .i_mstatus_mie  (mstatus_mie),
    .i_mie_msie     (mie_msie),
    .i_mie_mtie     (mie_mtie),
    .i_mie_meie     (mie_meie),
    .i_msip         (msip_l),
    .i_mtip         (i_mtip),
    .i_meip         (meip_l),
    .o_new_irq      (o_new_irq),
    .o_irq_code     (irq_code)
  );

endmodule

// File: tb/tb_serv_csr_mi.sv
// Bench for serv_csr_mi at W=4: vector table plus irq/trap/reset sequences.
// Expected read/write words queue up per instruction and are popped at its end.
module tb_serv_csr_mi;
  import serv_csr_mi_pkg::*;

  localparam int W = 4;
  localparam int NCH = 32 / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         init, en, cnt_done;
  logic [4:0]   bitpos;
  logic         mem_op, mem_cmd, e_op, ebreak;
  logic         trap, mret;
  logic         mstatus_en, mie_en, mip_en, mcause_en;
  logic [1:0]   src;
  logic         d_sel;
  logic [W-1:0] imm, rs1, rf;
  logic         mtip, msip, meip;
  logic         new_irq;
  logic [W-1:0] csr_in, q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serv_csr_mi #(
    .W              (W),
    .RESET_STRATEGY ("MINI"),
    .WITH_MSIP_MEIP (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_init       (init),
    .i_en         (en),
    .i_bitpos     (bitpos),
    .i_cnt_done   (cnt_done),
    .i_mem_op     (mem_op),
    .i_mem_cmd    (mem_cmd),
    .i_e_op       (e_op),
    .i_ebreak     (ebreak),
    .i_trap       (trap),
    .i_mret       (mret),
    .i_mstatus_en (mstatus_en),
    .i_mie_en     (mie_en),
    .i_mip_en     (mip_en),
    .i_mcause_en  (mcause_en),
    .i_csr_source (src),
    .i_csr_d_sel  (d_sel),
    .i_csr_imm    (imm),
    .i_rs1        (rs1),
    .i_rf_csr_out (rf),
    .i_mtip       (mtip),
    .i_msip       (msip),
    .i_meip       (meip),
    .o_new_irq    (new_irq),
    .o_csr_in     (csr_in),
    .o_q          (q)
  );

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] q;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [1:0]  src;
    bit          use_imm;
    logic [31:0] d;
    logic [31:0] rf;
    bit          chk;
    logic [31:0] q;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  localparam logic [3:0] S_MST = 4'b0001;
  localparam logic [3:0] S_MIE = 4'b0010;
  localparam logic [3:0] S_MIP = 4'b0100;
  localparam logic [3:0] S_MCA = 4'b1000;
  localparam logic [3:0] S_NONE = 4'b0000;

  function automatic logic [31:0] wd_of(
    input logic [1:0] s, input logic [31:0] qv, input logic [31:0] dv);
    case (s)
      2'b01:   return dv;
      2'b10:   return qv | dv;
      2'b11:   return qv & ~dv;
      default: return qv;
    endcase
  endfunction

  function automatic vec_t mk(string n, logic [3:0] s, logic [1:0] so,
      bit ui, logic [31:0] dv, logic [31:0] rv, bit c, logic [31:0] qv);
    vec_t v;
    v.name = n; v.sel = s; v.src = so; v.use_imm = ui;
    v.d = dv; v.rf = rv; v.chk = c; v.q = qv;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic push(string n, bit c, logic [31:0] qv, logic [31:0] wv);
    exp_t e;
    e.name = n; e.chk = c; e.q = qv; e.wd = wv;
    sb.push_back(e);
  endtask

  task automatic idle();
    en = 0; bitpos = 0; cnt_done = 0; init = 0;
    trap = 0; mret = 0;
    mstatus_en = 0; mie_en = 0; mip_en = 0; mcause_en = 0;
    src = 0; d_sel = 0; imm = 0; rs1 = 0; rf = 0;
  endtask

  task automatic run_instr(input logic [3:0] sel, input logic [1:0] so,
      input bit ui, input logic [31:0] dv, input logic [31:0] rv,
      input bit tr, input bit mr, input bit in);
    logic [31:0] qw, ww;
    exp_t e;
    qw = '0; ww = '0;
    for (int c = 0; c < NCH; c++) begin
      @(posedge clk); #1;
      en = 1; bitpos = 5'(c * W); cnt_done = (c == NCH - 1);
      init = in; trap = tr; mret = mr && (c == NCH - 1);
      mstatus_en = sel[0]; mie_en = sel[1];
      mip_en = sel[2]; mcause_en = sel[3];
      src = so; d_sel = ui;
      imm = ui ? dv[c*W +: W] : ~dv[c*W +: W];
      rs1 = ui ? ~dv[c*W +: W] : dv[c*W +: W];
      rf = rv[c*W +: W];
      #2;
      qw[c*W +: W] = q;
      ww[c*W +: W] = csr_in;
    end
    @(posedge clk); #1;
    idle();
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (e.chk) begin
        chk({e.name, "_q"}, qw, e.q);
        chk({e.name, "_wd"}, ww, e.wd);
      end
    end
  endtask

  task automatic rd(string n, logic [3:0] sel, logic [31:0] qv, bit in = 0);
    push(n, 1, qv, qv);
    run_instr(sel, CSR_SOURCE_CSR, 0, 32'h0, 32'h0, 0, 0, in);
  endtask

  task automatic do_trap(string n);
    push(n, 1, 32'h0, 32'h0);
    run_instr(S_NONE, CSR_SOURCE_CSR, 0, 32'h0, 32'h0, 1, 0, 0);
  endtask

  task automatic do_mret(string n);
    push(n, 1, 32'h0, 32'h0);
    run_instr(S_NONE, CSR_SOURCE_CSR, 0, 32'h0, 32'h0, 0, 1, 0);
  endtask

  initial begin
    rst = 1;
    idle();
    mem_op = 0; mem_cmd = 0; e_op = 0; ebreak = 0;
    mtip = 0; msip = 0; meip = 0;
    repeat (3) @(posedge clk);
    #1 chk("rst_irq", 32'(new_irq), 32'd0);
    rst = 0;

    tbl.push_back(mk("rd_mst0",  S_MST, 2'b00, 0, 32'h0,        32'h0,        1, 32'h1800));
    tbl.push_back(mk("csrrsi",   S_MST, 2'b10, 1, 32'h8,        32'h0,        1, 32'h1800));
    tbl.push_back(mk("rd_mst1",  S_MST, 2'b00, 0, 32'h0,        32'h0,        1, 32'h1808));
    tbl.push_back(mk("wr_mie",   S_MIE, 2'b01, 0, 32'h888,      32'h0,        1, 32'h0));
    tbl.push_back(mk("rd_mie",   S_MIE, 2'b00, 0, 32'h0,        32'h0,        1, 32'h888));
    tbl.push_back(mk("wr_mip",   S_MIP, 2'b01, 0, 32'hFFFFFFFF, 32'h0,        1, 32'h0));
    tbl.push_back(mk("rd_mip",   S_MIP, 2'b00, 0, 32'h0,        32'h0,        1, 32'h0));
    tbl.push_back(mk("rd_mie2",  S_MIE, 2'b00, 0, 32'h0,        32'h0,        1, 32'h888));
    tbl.push_back(mk("clr_msie", S_MIE, 2'b11, 0, 32'h8,        32'h0,        1, 32'h888));
    tbl.push_back(mk("rd_mie3",  S_MIE, 2'b00, 0, 32'h0,        32'h0,        1, 32'h880));
    tbl.push_back(mk("set_msie", S_MIE, 2'b10, 1, 32'h8,        32'h0,        1, 32'h880));
    tbl.push_back(mk("rf_ext",   S_NONE,2'b01, 0, 32'h12345678, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    tbl.push_back(mk("rf_set",   S_NONE,2'b10, 0, 32'h0F,       32'hF0,       1, 32'hF0));
    tbl.push_back(mk("wr_mca",   S_MCA, 2'b01, 0, 32'h800000FA, 32'h0,        0, 32'h0));
    tbl.push_back(mk("rd_mca",   S_MCA, 2'b00, 0, 32'h0,        32'h0,        1, 32'h8000000A));
    tbl.push_back(mk("wr_mca2",  S_MCA, 2'b01, 1, 32'h5,        32'h0,        1, 32'h8000000A));
    tbl.push_back(mk("rd_mca2",  S_MCA, 2'b00, 0, 32'h0,        32'h0,        1, 32'h5));

    foreach (tbl[i]) begin
      push(tbl[i].name, tbl[i].chk, tbl[i].q,
           wd_of(tbl[i].src, tbl[i].q, tbl[i].d));
      run_instr(tbl[i].sel, tbl[i].src, tbl[i].use_imm,
                tbl[i].d, tbl[i].rf, 0, 0, 0);
      chk({tbl[i].name, "_irq"}, 32'(new_irq), 32'd0);
    end

    // Timer and external pending together: external wins.
    mtip = 1; meip = 1;
    rd("mip_te", S_MIP, 32'h880);
    chk("irq_te", 32'(new_irq), 32'd1);
    do_trap("trap_mei");
    chk("irq_clr", 32'(new_irq), 32'd0);
    rd("mca_mei", S_MCA, 32'h8000000B);
    rd("mst_trap", S_MST, 32'h1880);

    // External held through mret re-triggers on the next instruction.
    mtip = 0;
    do_mret("mret1");
    chk("irq_mret", 32'(new_irq), 32'd0);
    rd("mst_mret", S_MST, 32'h1888);
    chk("irq_retrig", 32'(new_irq), 32'd1);
    do_trap("trap_mei2");

    // Software beats timer.
    meip = 0; msip = 1; mtip = 1;
    do_mret("mret2");
    rd("mca_old", S_MCA, 32'h8000000B);
    chk("irq_msi", 32'(new_irq), 32'd1);
    do_trap("trap_msi");
    rd("mca_msi", S_MCA, 32'h80000003);

    // Synchronous exceptions with no pending irq.
    msip = 0; mtip = 0;
    mem_op = 1; mem_cmd = 1;
    do_trap("trap_smis");
    mem_op = 0; mem_cmd = 0;
    rd("mca_smis", S_MCA, 32'h6);
    e_op = 1; ebreak = 1;
    do_trap("trap_ebrk");
    e_op = 0; ebreak = 0;
    rd("mca_ebrk", S_MCA, 32'h3);
    e_op = 1;
    do_trap("trap_ecall");
    e_op = 0;
    rd("mca_ecall", S_MCA, 32'hB);
    mem_op = 1;
    do_trap("trap_lmis");
    mem_op = 0;
    rd("mca_lmis", S_MCA, 32'h4);
    do_trap("trap_jmis");
    rd("mca_jmis", S_MCA, 32'h0);
    chk("irq_exc", 32'(new_irq), 32'd0);

    // Init-phase instruction ends do not sample irqs.
    push("mst_en", 1, 32'h1800, 32'h1808);
    run_instr(S_MST, CSR_SOURCE_SET, 0, 32'h8, 32'h0, 0, 0, 0);
    mtip = 1;
    rd("mip_init", S_MIP, 32'h80, 1);
    chk("irq_init", 32'(new_irq), 32'd0);
    rd("mip_run", S_MIP, 32'h80);
    chk("irq_run", 32'(new_irq), 32'd1);

    // Asynchronous reset away from the clock edge.
    @(posedge clk); #3;
    rst = 1;
    #1 chk("arst_irq", 32'(new_irq), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    rd("mie_arst", S_MIE, 32'h0);
    rd("mst_arst", S_MST, 32'h1800);
    chk("irq_arst", 32'(new_irq), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
